// File: rtl/wb_exmem_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the exmem slave.
// Grant is held for the whole owner cycle; a watchdog error-terminates stalled strobes.
module wb_exmem_arbiter #(
  parameter int unsigned BITS    = 32,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic            wbs_clk_i,
  input  logic            wbs_rst_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [3:0]      m0_sel_i,
  input  logic [BITS-1:0] m0_adr_i,
  input  logic [BITS-1:0] m0_dat_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic [BITS-1:0] m0_dat_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [3:0]      m1_sel_i,
  input  logic [BITS-1:0] m1_adr_i,
  input  logic [BITS-1:0] m1_dat_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [BITS-1:0] m1_dat_o,
  output logic            wbs_cyc_o_exmem,
  output logic            wbs_stb_o_exmem,
  output logic            wbs_we_o_exmem,
  output logic [3:0]      wbs_sel_o_exmem,
  output logic [BITS-1:0] wbs_adr_o_exmem,
  output logic [BITS-1:0] wbs_dat_o_exmem,
  input  logic            wbs_ack_i_exmem,
  input  logic [BITS-1:0] wbs_dat_i_exmem,
  output logic [1:0]      grant_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;   // 0 = m0 owned last, 1 = m1
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [1:0]       grant_q, grant_d;
  logic             req0, req1, timeout;

  assign req0    = m0_cyc_i & m0_stb_i;
  assign req1    = m1_cyc_i & m1_stb_i;
  assign timeout = (state_q != IDLE) && (tcnt_q == CNT_W'(TIMEOUT));
  assign grant_o = grant_q;

  always_ff @(posedge wbs_clk_i or negedge wbs_rst_i) begin
    if (!wbs_rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      tcnt_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
      grant_q <= grant_d;
    end
  end

  // Exits to IDLE on cyc drop or timeout; the other master waits one IDLE cycle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    tcnt_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = last_q ? GNT0 : GNT1;
        else if (req0)     state_d = GNT0;
        else if (req1)     state_d = GNT1;
      end
      GNT0: begin
        if (timeout || !m0_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end else if (m0_stb_i && !wbs_ack_i_exmem) begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end
      GNT1: begin
        if (timeout || !m1_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end else if (m1_stb_i && !wbs_ack_i_exmem) begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    unique case (state_d)
      GNT0:    grant_d = 2'b01;
      GNT1:    grant_d = 2'b10;
      default: grant_d = 2'b00;
    endcase
  end

  always_comb begin
    wbs_cyc_o_exmem = 1'b0;
    wbs_stb_o_exmem = 1'b0;
    wbs_we_o_exmem  = 1'b0;
    wbs_sel_o_exmem = '0;
    wbs_adr_o_exmem = '0;
    wbs_dat_o_exmem = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    unique case (state_q)
      GNT0: begin
        wbs_cyc_o_exmem = m0_cyc_i & ~timeout;
        wbs_stb_o_exmem = m0_stb_i & ~timeout;
        wbs_we_o_exmem  = m0_we_i;
        wbs_sel_o_exmem = m0_sel_i;
        wbs_adr_o_exmem = m0_adr_i;
        wbs_dat_o_exmem = m0_dat_i;
        m0_ack_o        = wbs_ack_i_exmem & ~timeout;
        m0_err_o        = timeout;
        m0_dat_o        = wbs_dat_i_exmem;
      end
      GNT1: begin
        wbs_cyc_o_exmem = m1_cyc_i & ~timeout;
        wbs_stb_o_exmem = m1_stb_i & ~timeout;
        wbs_we_o_exmem  = m1_we_i;
        wbs_sel_o_exmem = m1_sel_i;
        wbs_adr_o_exmem = m1_adr_i;
        wbs_dat_o_exmem = m1_dat_i;
        m1_ack_o        = wbs_ack_i_exmem & ~timeout;
        m1_err_o        = timeout;
        m1_dat_o        = wbs_dat_i_exmem;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_exmem_arbiter.sv
// Directed self-checking bench for wb_exmem_arbiter (watchdog shortened to 4 cycles).
module tb_wb_exmem_arbiter;

  localparam int unsigned BITS = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
  logic [3:0]      m0_sel = '0;
  logic [BITS-1:0] m0_adr = '0, m0_wdat = '0;
  logic            m0_ack, m0_err;
  logic [BITS-1:0] m0_rdat;
  logic            m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
  logic [3:0]      m1_sel = '0;
  logic [BITS-1:0] m1_adr = '0, m1_wdat = '0;
  logic            m1_ack, m1_err;
  logic [BITS-1:0] m1_rdat;
  logic            s_cyc, s_stb, s_we;
  logic [3:0]      s_sel;
  logic [BITS-1:0] s_adr, s_wdat;
  logic            s_ack = 1'b0;
  logic [BITS-1:0] s_rdat = '0;
  logic [1:0]      grant;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  wb_exmem_arbiter #(.BITS(BITS), .TIMEOUT(4), .CNT_W(8)) dut (
    .wbs_clk_i(clk), .wbs_rst_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_dat_o(m0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_dat_o(m1_rdat),
    .wbs_cyc_o_exmem(s_cyc), .wbs_stb_o_exmem(s_stb), .wbs_we_o_exmem(s_we),
    .wbs_sel_o_exmem(s_sel), .wbs_adr_o_exmem(s_adr), .wbs_dat_o_exmem(s_wdat),
    .wbs_ack_i_exmem(s_ack), .wbs_dat_i_exmem(s_rdat),
    .grant_o(grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic exp_owner;

  initial begin
    // Reset state
    settle();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_slave", 32'({s_cyc, s_stb, s_we}), 32'h0);
    check("rst_acks", 32'({m0_ack, m0_err, m1_ack, m1_err}), 32'h0);
    do_reset();

    // Single m0 read, slave acks two cycles after its stb
    m0_cyc = 1; m0_stb = 1; m0_sel = 4'hF; m0_adr = 32'h3840_0010;
    settle();
    check("idle_no_stb", 32'(s_stb), 32'h0);
    tick(); settle();
    check("m0_stb_up", 32'(s_stb), 32'h1);
    check("m0_adr", s_adr, 32'h3840_0010);
    check("m0_grant", 32'(grant), 32'h1);
    tick(); settle();
    check("m0_noack_yet", 32'(m0_ack), 32'h0);
    tick();
    s_ack = 1; s_rdat = 32'hDEAD_BEEF;
    settle();
    check("m0_ack", 32'(m0_ack), 32'h1);
    check("m0_dat", m0_rdat, 32'hDEAD_BEEF);
    check("m1_quiet", 32'({m1_ack, m1_err}) | m1_rdat, 32'h0);
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    settle();
    check("m0_grant_hold", 32'(grant), 32'h1);
    tick(); settle();
    check("m0_release", 32'(grant), 32'h0);

    // Simultaneous request straight from reset: m0 wins, m1 follows after an IDLE cycle
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h3840_0020;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h3840_0040;
    tick();
    s_ack = 1;
    settle();
    check("tie_grant", 32'(grant), 32'h1);
    check("tie_acks", 32'({m1_ack, m0_ack}), 32'h1);
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick(); settle();
    check("tie_idle_gap", 32'(grant), 32'h0);
    check("tie_idle_stb", 32'(s_stb), 32'h0);
    tick();
    s_ack = 1;
    settle();
    check("tie_m1_grant", 32'(grant), 32'h2);
    check("tie_m1_adr", s_adr, 32'h3840_0040);
    check("tie_m1_ack", 32'({m1_ack, m0_ack}), 32'h2);
    tick();
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    tick();

    // Round robin across 8 contended transactions; m1 owned last
    exp_owner = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      tick();
      s_ack = 1;
      settle();
      check($sformatf("rr_grant%0d", i), 32'(grant), exp_owner ? 32'h2 : 32'h1);
      check($sformatf("rr_ack%0d", i), 32'({m1_ack, m0_ack}), exp_owner ? 32'h2 : 32'h1);
      tick();
      s_ack = 0; m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
      tick();
      exp_owner = ~exp_owner;
    end

    // Burst hold: m1 keeps cyc for four beats while m0 waits
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h3840_0000;
    tick();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h3840_0100;
    for (int b = 0; b < 4; b++) begin
      m1_adr = 32'h3840_0000 + 32'(4 * b);
      s_ack = 1;
      settle();
      check($sformatf("burst_adr%0d", b), s_adr, 32'h3840_0000 + 32'(4 * b));
      check($sformatf("burst_m0ack%0d", b), 32'({m0_ack, m1_ack}), 32'h1);
      tick();
    end
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    settle();
    check("burst_hold_grant", 32'(grant), 32'h2);
    tick(); settle();
    check("burst_idle", 32'(grant), 32'h0);
    tick(); settle();
    check("burst_m0_grant", 32'(grant), 32'h1);
    s_ack = 1;
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick();

    // Watchdog: m0 strobes, slave never acks in time
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h3840_0200;
    tick(); settle();
    check("wd_stb_up", 32'(s_stb), 32'h1);
    tick(); tick(); tick(); settle();
    check("wd_no_err_early", 32'(m0_err), 32'h0);
    tick();
    s_ack = 1;
    settle();
    check("wd_err", 32'(m0_err), 32'h1);
    check("wd_slave_off", 32'({s_cyc, s_stb}), 32'h0);
    check("wd_late_ack", 32'(m0_ack), 32'h0);
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    settle();
    check("wd_idle", 32'(grant), 32'h0);
    check("wd_err_once", 32'(m0_err), 32'h0);
    tick();

    // Asynchronous reset in the middle of an m1 cycle
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h3840_0300;
    tick(); settle();
    check("ar_grant", 32'(grant), 32'h2);
    s_ack = 1;
    #1 rst_n = 1'b0;
    #1;
    check("ar_slave_off", 32'({s_cyc, s_stb}), 32'h0);
    check("ar_acks_off", 32'({m1_ack, m1_err, m0_ack, m0_err}), 32'h0);
    check("ar_grant_off", 32'(grant), 32'h0);
    s_ack = 0;
    tick();
    rst_n = 1'b1;
    tick(); settle();
    check("ar_regrant", 32'(grant), 32'h2);
    tick(); tick(); tick(); settle();
    check("ar_tcnt_fresh", 32'(m1_err), 32'h0);
    tick(); settle();
    check("ar_wd_err", 32'(m1_err), 32'h1);
    m1_cyc = 0; m1_stb = 0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
